// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit-side blocks.
package uart_pkg;

    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned MAX_REQ = 8;

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT_START,
        WAIT_DONE
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority picker: first eligible requester after ptr wins.
module rr_arbiter #(
    parameter int unsigned N = 4,
    localparam int unsigned IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    input  logic [N-1:0]     mask,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    logic [N-1:0] elig;
    logic         found;
    int unsigned  cand;

    assign elig = req & mask;
    assign any  = |elig;

    // Scan ptr+1, ptr+2, ... ptr+N (mod N); the last slot checked is ptr itself.
    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        cand  = 0;
        for (int unsigned k = 1; k <= N; k++) begin
            cand = (32'(ptr) + k) % N;
            if (!found && elig[IDX_W'(cand)]) begin
                found              = 1'b1;
                gnt[IDX_W'(cand)]  = 1'b1;
                idx                = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx among NUM_REQ byte producers with round-robin order and
// optional per-requester lock for multi-byte messages.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [BYTE_W*NUM_REQ-1:0]   req_data,
    input  logic [NUM_REQ-1:0]          req_lock,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic [NUM_REQ-1:0]          grant,
    output logic                        busy,
    output logic [BYTE_W-1:0]           tx_data,
    output logic                        tx_en,
    input  logic                        baud_en,
    input  logic                        tx_rdy
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    state_t               state;
    logic [IDX_W-1:0]     ptr;
    logic [NUM_REQ-1:0]   lock_mask;
    logic                 cur_lock;

    logic [NUM_REQ-1:0]   arb_mask;
    logic [NUM_REQ-1:0]   arb_gnt;
    logic [IDX_W-1:0]     arb_idx;
    logic                 arb_any;
    logic [BYTE_W-1:0]    sel_data;
    logic                 sel_lock;

    // With a lock held only the owner is eligible; otherwise everyone is.
    assign arb_mask = (|lock_mask) ? lock_mask : '1;

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .req  (req_valid),
        .ptr  (ptr),
        .mask (arb_mask),
        .gnt  (arb_gnt),
        .idx  (arb_idx),
        .any  (arb_any)
    );

    always_comb begin
        sel_data = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (arb_gnt[i]) begin
                sel_data = req_data[i*BYTE_W +: BYTE_W];
            end
        end
        sel_lock = |(arb_gnt & req_lock);
    end

    // Sequencer: accept byte, hold tx_en until baud tick, then follow tx_rdy through the frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            ptr       <= IDX_W'(NUM_REQ - 1);
            lock_mask <= '0;
            cur_lock  <= 1'b0;
            req_ready <= '0;
            grant     <= '0;
            busy      <= 1'b0;
            tx_data   <= '0;
            tx_en     <= 1'b0;
        end else begin
            req_ready <= '0;
            case (state)
                IDLE: begin
                    if (tx_rdy && arb_any) begin
                        tx_data   <= sel_data;
                        grant     <= arb_gnt;
                        req_ready <= arb_gnt;
                        ptr       <= arb_idx;
                        cur_lock  <= sel_lock;
                        tx_en     <= 1'b1;
                        busy      <= 1'b1;
                        state     <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    if (baud_en) begin
                        tx_en <= 1'b0;
                        state <= WAIT_START;
                    end
                end
                WAIT_START: begin
                    if (!tx_rdy) begin
                        state <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (tx_rdy) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        // A locked owner keeps grant so nobody else interleaves.
                        if (cur_lock) begin
                            lock_mask <= grant;
                        end else begin
                            lock_mask <= '0;
                            grant     <= '0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter and sequencer that shares the single `uart_tx` transmitter (9600-baud `baud_generator` timebase) among `NUM_REQ` byte producers. It accepts one byte at a time from the selected requester and drives `tx_data`/`tx_en` with the hold-until-`baud_en` rule that `uart_tx` needs. It tracks `tx_rdy` through each frame, and supports an optional per-requester lock so a multi-byte message goes out without interleaving. It sits between the application producers and `uart_tx` in `main`.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8
- `clk`  in  1  system clock
- `rst`  in  1  reset, asynchronous, active-low
- `req_valid`  in  NUM_REQ  requester i has a byte on `req_data[8i+7:8i]`
- `req_data`  in  8*NUM_REQ  packed request bytes
- `req_lock`  in  NUM_REQ  keep grant after this byte if more bytes follow
- `req_ready`  out  NUM_REQ  one-cycle pulse: byte of requester i accepted
- `grant`  out  NUM_REQ  one-hot owner of the transmitter, 0 when free
- `busy`  out  1  state != IDLE
- `tx_data`  out  8  byte to `uart_tx`
- `tx_en`  out  1  launch request to `uart_tx`
- `baud_en`  in  1  baud tick from `baud_generator`
- `tx_rdy`  in  1  `uart_tx` idle/ready

## Operation
- FSM states: IDLE, LAUNCH, WAIT_START, WAIT_DONE.
- **IDLE**
  - When `tx_rdy`=1 and any `req_valid`, choose winner w by round-robin, starting at `ptr+1` mod NUM_REQ.
  - Latch `tx_data` from requester w's byte and set `grant`=onehot(w).
  - Pulse `req_ready[w]`, set `ptr`=w, assert `tx_en`, and go to LAUNCH.
  - If a lock is held (`lock_owner` valid), only that requester is eligible and others are ignored.
- **LAUNCH**: hold `tx_en`=1 and `tx_data` stable. On a cycle with `baud_en`=1, drop `tx_en` next cycle and go to WAIT_START.
- **WAIT_START**: wait for `tx_rdy`=0, then go to WAIT_DONE.
- **WAIT_DONE**: wait for `tx_rdy`=1, then go to IDLE.
  - If the owner's `req_lock` was 1 when its byte was accepted, record `lock_owner`=w and keep `grant` asserted.
  - Otherwise clear `grant` and `lock_owner`.
- Lock release:
  - A locked owner that presents a byte with `req_lock`=0 is served, and the lock clears at the end of that frame.
  - A locked owner that drops `req_valid` keeps the lock. No timeout.
- `ptr` advances only on grant. A locked owner is re-granted without affecting the fairness order for other requesters.
- `req_ready` is the only acceptance indication. Requesters change `req_data` only after their `req_ready` pulse.

## Timing
- Reset (async assert, sync deassert by the top level) forces:
  - state=IDLE, `tx_en`=0, `tx_data`=0x00, `grant`=0, `req_ready`=0, `busy`=0
  - `ptr`=NUM_REQ-1, so requester 0 is served first; `lock_owner` cleared
- Reset mid-frame: outputs go to reset values immediately. `uart_tx` has its own reset.
- Grant latency: request seen in IDLE at cycle t gives `req_ready`, `grant`, `tx_data` and `tx_en` registered at t+1.
- `tx_en` width: from t+1 up to and including the first cycle with `baud_en`=1, then deasserted.
  - If `baud_en`=1 on cycle t+1 itself, `tx_en` lasts exactly 1 cycle.
- Back-to-back: the earliest next grant is the cycle after WAIT_DONE sees `tx_rdy`=1, so there is no gap beyond one clk between frames.
- Simultaneous requests resolve by rotation only. If `req_valid` drops in the same cycle as the grant decision, that requester is not served.
- If `tx_rdy`=0 in IDLE (transmitter busy after reset), no grant is issued.

## Structure
- Shared package `uart_pkg`:
  - `BYTE_W`=8
  - state enum (IDLE, LAUNCH, WAIT_START, WAIT_DONE)
  - `MAX_REQ`=8
- Sub-module `rr_arbiter`: combinational rotating-priority pick from `req` vector, `ptr` and a `mask` (the lock).
  - Outputs a one-hot `gnt` and an index.
  - Reusable for future RX-side sharing.
- The top of the block holds the FSM, `ptr`, `lock_owner` and output registers.

## Test plan
- After reset: requester 2 sends 0x41 → `req_ready[2]` pulses once, `tx_en` high until the first `baud_en`, then frame 0x41 on `RsTx`, `grant` returns to 0.
- All four requesters valid with 0x10..0x13 → transmit order 0x10, 0x11, 0x12, 0x13, then requester 0 again, with exactly one `req_ready` pulse per byte.
- Requester 1 sends 0xA0, 0xA1 (lock=1) and 0xA2 (lock=0) while requester 3 is valid with 0x55 → order A0, A1, A2, 55, and `grant` is held at 0b0010 across A0..A2.
- `baud_en` coincident with the grant cycle+1 → `tx_en` is 1 cycle wide and the byte is still sent.
- Reset asserted during WAIT_DONE → `tx_en`, `grant`, `busy`=0 within the same cycle; the first request after reset is served from requester 0.
- `tx_rdy` held 0 after reset with requests pending → no `req_ready` and no `tx_en` until `tx_rdy`=1.
